// File: rtl/uart_tx_driver.sv
// uart_tx_driver: UART frame serializer; in_valid/in_ready/in_bits byte in, registered txd out, busy while framing, frame_count of completed frames
module uart_tx_driver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_bits,
  output logic        txd,
  output logic        busy,
  output logic [15:0] frame_count
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [15:0] LAST      = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [7:0]  MASK      = 8'((1 << DATA_BITS) - 1);
  state_t state_q, state_d;
  logic [15:0] cyc_q, cyc_d, frame_count_q, frame_count_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic par_q, par_d, txd_q, txd_d, rdy_q, rdy_d, tick;
  assign tick = cyc_q == LAST;
  always_comb begin
    state_d = state_q;
    cyc_d = tick ? '0 : cyc_q + 16'd1;
    bit_d = bit_q;
    shift_d = shift_q;
    par_d = par_q;
    txd_d = txd_q;
    rdy_d = 1'b0;
    frame_count_d = frame_count_q;
    case (state_q)
      IDLE: begin
        cyc_d = '0;
        txd_d = 1'b1;
        rdy_d = 1'b1;
        if (in_valid && rdy_q) begin
          shift_d = in_bits;
          par_d = ^(in_bits & MASK) ^ 1'(PARITY_ODD);
          state_d = START;
          txd_d = 1'b0;
          rdy_d = 1'b0;
        end
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d = '0;
        txd_d = shift_q[0];
      end
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + 3'd1;
        txd_d = shift_q[1];
        if (bit_q == LAST_BIT) begin
          bit_d = '0;
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
          txd_d = (PARITY_EN != 0) ? par_q : 1'b1;
        end
      end
      PARITY: if (tick) begin
        state_d = STOP;
        txd_d = 1'b1;
      end
      STOP: if (tick) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == LAST_STOP) begin
          bit_d = '0;
          state_d = IDLE;
          rdy_d = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cyc_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      txd_q <= 1'b1;
      rdy_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q <= cyc_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_q <= par_d;
      txd_q <= txd_d;
      rdy_q <= rdy_d;
      frame_count_q <= frame_count_d;
    end
  end
  assign in_ready = rdy_q;
  assign txd = txd_q;
  assign busy = state_q != IDLE;
  assign frame_count = frame_count_q;
endmodule

// File: tb/tb_uart_tx_driver.sv
// tb_uart_tx_driver: directed self-checking bench for a plain and a parity-enabled uart_tx_driver
module tb_uart_tx_driver;
  logic clk = 1'b0, rst = 1'b1;
  logic v = 1'b0, pv = 1'b0;
  logic [7:0] b = 8'h00, pb = 8'h00;
  logic rdy, txd, busy, prdy, ptxd, pbusy;
  logic [15:0] fc, pfc;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  uart_tx_driver #(.CLKS_PER_BIT(4)) dut (
    .clock(clk), .reset(rst), .in_valid(v), .in_ready(rdy), .in_bits(b),
    .txd(txd), .busy(busy), .frame_count(fc));
  uart_tx_driver #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clock(clk), .reset(rst), .in_valid(pv), .in_ready(prdy), .in_bits(pb),
    .txd(ptxd), .busy(pbusy), .frame_count(pfc));
  function automatic logic [127:0] expand(input logic [15:0] slots, input int ns);
    logic [127:0] r = '0;
    for (int i = 0; i < ns * 4; i++) r[i] = slots[i / 4];
    return r;
  endfunction
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; v = 1'b0; pv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic launch(input bit p, input logic [7:0] d, input bit hold);
    int k = 0;
    while ((p ? prdy : rdy) !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      total++; bad++;
      $display("FAIL launch_timeout: in_ready=%b required 1", p ? prdy : rdy);
    end
    if (p) begin pv = 1'b1; pb = d; end else begin v = 1'b1; b = d; end
    @(negedge clk);
    if (!hold) begin
      if (p) begin pv = 1'b0; pb = ~d; end else begin v = 1'b0; b = ~d; end
    end
  endtask
  task automatic capture(input bit p, input int n, output logic [127:0] w, output int bc);
    w = '0; bc = 0;
    for (int i = 0; i < n; i++) begin
      w[i] = p ? ptxd : txd;
      bc += int'(p ? pbusy : busy);
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1; v = 1'b1; pv = 1'b1; b = 8'hA5; pb = 8'hA5;
    repeat (4) @(negedge clk);
    total++;
    if ({txd, busy, rdy, fc} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL reset_state: txd=%b busy=%b rdy=%b fc=%h required 1 0 0 0000", txd, busy, rdy, fc);
    end
    total++;
    if ({ptxd, pbusy, prdy, pfc} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL reset_state_p: txd=%b busy=%b rdy=%b fc=%h required 1 0 0 0000", ptxd, pbusy, prdy, pfc);
    end
    v = 1'b0; pv = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({txd, busy, rdy} !== 3'b101) begin
      bad++;
      $display("FAIL post_reset_idle: txd=%b busy=%b rdy=%b required 1 0 1", txd, busy, rdy);
    end
  endtask
  task automatic test_single;
    logic [127:0] w;
    int bc;
    do_reset;
    launch(0, 8'hA5, 0);
    capture(0, 40, w, bc);
    total++;
    if (w !== expand({1'b1, 8'hA5, 1'b0}, 10)) begin
      bad++;
      $display("FAIL single_wave: got %h required %h", w[39:0], expand({1'b1, 8'hA5, 1'b0}, 10) & 128'hFF_FFFF_FFFF);
    end
    total++;
    if (bc !== 40) begin bad++; $display("FAIL single_busy: got %0d required 40", bc); end
    total++;
    if ({txd, busy, rdy, fc} !== {1'b1, 1'b0, 1'b1, 16'h0001}) begin
      bad++;
      $display("FAIL single_end: txd=%b busy=%b rdy=%b fc=%h required 1 0 1 0001", txd, busy, rdy, fc);
    end
  endtask
  task automatic test_parity;
    logic [127:0] w;
    int bc;
    do_reset;
    launch(1, 8'hA5, 0);
    capture(1, 44, w, bc);
    total++;
    if (w !== expand({1'b1, 1'b0, 8'hA5, 1'b0}, 11)) begin
      bad++;
      $display("FAIL parity_a5_wave: got %h", w[43:0]);
    end
    total++;
    if (bc !== 44) begin bad++; $display("FAIL parity_busy: got %0d required 44", bc); end
    launch(1, 8'h01, 0);
    capture(1, 44, w, bc);
    total++;
    if (w !== expand({1'b1, 1'b1, 8'h01, 1'b0}, 11)) begin
      bad++;
      $display("FAIL parity_01_wave: got %h", w[43:0]);
    end
    total++;
    if (pfc !== 16'h0002) begin bad++; $display("FAIL parity_count: got %h required 0002", pfc); end
  endtask
  task automatic test_back_to_back;
    logic [127:0] w1, w2, e;
    int bc1, bc2;
    do_reset;
    launch(0, 8'h00, 1);
    b = 8'hFF;
    capture(0, 50, w1, bc1);
    v = 1'b0;
    capture(0, 31, w2, bc2);
    e = expand({1'b1, 8'h00, 1'b0}, 10) | (128'd1 << 40) | (expand({1'b1, 8'hFF, 1'b0}, 10) << 41);
    total++;
    if ((w1 | (w2 << 50)) !== e) begin
      bad++;
      $display("FAIL b2b_wave: got %h required %h", w1 | (w2 << 50), e);
    end
    total++;
    if (bc1 + bc2 !== 80) begin bad++; $display("FAIL b2b_busy: got %0d required 80", bc1 + bc2); end
    total++;
    if ({busy, fc} !== {1'b0, 16'h0002}) begin
      bad++;
      $display("FAIL b2b_end: busy=%b fc=%h required 0 0002", busy, fc);
    end
  endtask
  task automatic test_busy_ignore;
    logic [127:0] w = '0;
    bit rdy_seen = 1'b0, act = 1'b0;
    do_reset;
    launch(0, 8'h96, 0);
    for (int i = 0; i < 40; i++) begin
      w[i] = txd;
      if (rdy !== 1'b0) rdy_seen = 1'b1;
      if (i == 10) begin v = 1'b1; b = 8'h3C; end
      if (i == 20) b = 8'h55;
      if (i == 38) v = 1'b0;
      @(negedge clk);
    end
    total++;
    if (w !== expand({1'b1, 8'h96, 1'b0}, 10)) begin
      bad++;
      $display("FAIL ignore_wave: got %h", w[39:0]);
    end
    total++;
    if (rdy_seen) begin bad++; $display("FAIL ignore_ready: in_ready=1 while busy required 0"); end
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b0 || txd !== 1'b1) act = 1'b1;
      @(negedge clk);
    end
    total++;
    if (act || fc !== 16'h0001) begin
      bad++;
      $display("FAIL ignore_after: extra_activity=%b fc=%h required 0 0001", act, fc);
    end
  endtask
  task automatic test_reset_mid;
    logic [127:0] w;
    int bc;
    do_reset;
    launch(0, 8'h0F, 0);
    repeat (17) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b required 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({txd, busy, rdy, fc} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL mid_reset: txd=%b busy=%b rdy=%b fc=%h required 1 0 0 0000", txd, busy, rdy, fc);
    end
    rst = 1'b0;
    launch(0, 8'h5A, 0);
    capture(0, 40, w, bc);
    total++;
    if (w !== expand({1'b1, 8'h5A, 1'b0}, 10) || fc !== 16'h0001) begin
      bad++;
      $display("FAIL mid_resend: wave=%h fc=%h required %h 0001", w[39:0], fc, expand({1'b1, 8'h5A, 1'b0}, 10) & 128'hFF_FFFF_FFFF);
    end
  endtask
  task automatic test_wrap;
    logic [127:0] w;
    int bc;
    do_reset;
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    @(negedge clk);
    total++;
    if (fc !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload: got %h required ffff", fc); end
    launch(0, 8'h81, 0);
    capture(0, 40, w, bc);
    total++;
    if (fc !== 16'h0000) begin bad++; $display("FAIL wrap_count: got %h required 0000", fc); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_parity;
    test_back_to_back;
    test_busy_ignore;
    test_reset_mid;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx_driver.md
UART_TX_DRIVER -- requirements
Module: uart_tx_driver

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit; legal values are 2..65535.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal values are 5..8.
REQ-003 The block SHALL have parameter PARITY_EN, default 0, where 1 inserts one parity bit after the data bits.
REQ-004 The block SHALL have parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd parity; it is ignored when PARITY_EN=0.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, meaning the number of stop bits; legal values are 1..2.
REQ-006 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port in_valid, input, 1 bit: a byte is offered.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-010 The block SHALL have port in_bits, input, 8 bits: the byte offered; only bits [DATA_BITS-1:0] are transmitted.
REQ-011 The block SHALL have port txd, output, 1 bit: serial line to the DUT io_ua_rxd; idles high.
REQ-012 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-013 The block SHALL have port frame_count, output, 16 bits: the number of completed frames.

Function
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, and busy SHALL equal (state != IDLE).
REQ-015 in_ready SHALL be 1 only in IDLE, and a transfer SHALL occur on a cycle with in_valid && in_ready.
REQ-016 On a transfer, the block SHALL latch in_bits into a shift register and enter START on the next cycle; later in_bits changes SHALL NOT affect the frame.
REQ-017 In START, txd SHALL be 0 for exactly CLKS_PER_BIT cycles.
REQ-018 In DATA, the block SHALL drive DATA_BITS bits LSB first, each for exactly CLKS_PER_BIT cycles, using a bit-index counter and a cycle counter that reload at every bit boundary.
REQ-019 PARITY SHALL be entered only when PARITY_EN=1; txd SHALL be the XOR of the data bits, inverted when PARITY_ODD=1, held for CLKS_PER_BIT cycles.
REQ-020 In STOP, txd SHALL be 1 for STOP_BITS*CLKS_PER_BIT cycles, then the FSM SHALL return to IDLE.
REQ-021 frame_count SHALL increment by 1 on the cycle STOP exits to IDLE, and SHALL wrap from 0xFFFF to 0x0000.
REQ-022 In IDLE, txd SHALL be 1.
REQ-023 Back-to-back frames SHALL be separated by exactly one IDLE cycle (txd=1) when in_valid is held high.
REQ-024 in_valid while busy SHALL be ignored, with no buffering and no effect on the frame.
REQ-025 A frame SHALL occupy (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles with busy=1.
REQ-026 txd SHALL come directly from a flop, with no combinational path from inputs.

Reset
REQ-027 While reset=1 on a rising edge: state=IDLE, txd=1, busy=0, frame_count=0, counters=0, shift register=0.
REQ-028 While reset=1, in_ready SHALL be 0, and no transfer SHALL occur.
REQ-029 On reset mid-frame, the frame SHALL be abandoned, txd=1 on the next cycle, and frame_count SHALL NOT increment.

Verification
REQ-030 Single frame: CLKS_PER_BIT=4, default parameters, send 0xA5 -> txd = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; busy high for 40 cycles; frame_count=1.
REQ-031 Parity: PARITY_EN=1, PARITY_ODD=0, CLKS_PER_BIT=4, send 0xA5 -> parity bit 0 after bit 7, 44 busy cycles; send 0x01 -> parity bit 1.
REQ-032 Back-to-back: in_valid held high with 0x00 then 0xFF, CLKS_PER_BIT=4 -> second start bit begins exactly 1 cycle after the first frame's stop bit ends; frame_count=2.
REQ-033 Busy ignore: assert in_valid with 0x3C mid-frame and change in_bits -> the current frame is unchanged, 0x3C is not sent, and in_ready stays 0 until IDLE.
REQ-034 Reset mid-frame: assert reset during DATA bit 3 -> txd=1, busy=0, in_ready=0 the next cycle, frame_count unchanged at 0; after release, 0x5A is transmitted correctly.
REQ-035 Wrap: preload frame_count to 0xFFFF by force, complete one frame -> frame_count=0x0000.
